// File: rtl/sprite_pkg.sv
// Shared types and sizing helpers for the sprite compositor and its texture RAMs.
package sprite_pkg;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t KEY_COLOR_DEF = 16'h07E0;
    localparam int      PIX_W         = 11;
    localparam int      POS_W         = 12;

    function automatic int unsigned tex_depth(input int unsigned spr_w,
                                              input int unsigned spr_h,
                                              input int unsigned num_frm);
        return spr_w * spr_h * num_frm;
    endfunction

endpackage

// File: rtl/spr_tex_ram.sv
// Simple dual-port texture store: one write port, one registered read port, single clock.
module spr_tex_ram
    import sprite_pkg::*;
#(
    parameter int DEPTH = 12288,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  rgb565_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output rgb565_t       rd_data
);

    rgb565_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sprite_compositor.sv
// Composites NUM_SPR keyed, animated sprites over a background pixel stream, 2-cycle latency.
// Define SPR_MIRROR_EN to honour spr_flip (horizontal mirror); otherwise spr_flip is ignored.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int      NUM_SPR   = 4,
    parameter int      SPR_W     = 64,
    parameter int      SPR_H     = 48,
    parameter int      NUM_FRM   = 4,
    parameter rgb565_t KEY_COLOR = KEY_COLOR_DEF,
    parameter int      ANIM_DIV  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         pixel_x,
    input  logic [PIX_W-1:0]         pixel_y,
    input  logic                     pix_valid,
    input  rgb565_t                  bg_data,
    input  logic [NUM_SPR*POS_W-1:0] spr_x,
    input  logic [NUM_SPR*POS_W-1:0] spr_y,
    input  logic [NUM_SPR-1:0]       spr_en,
    input  logic [NUM_SPR-1:0]       spr_anim,
    input  logic [NUM_SPR-1:0]       spr_flip,
    input  logic                     frame_en,
    input  logic                     load_en,
    input  logic [2:0]               load_sel,
    input  logic [15:0]              load_addr,
    input  logic [15:0]              load_data,
    output rgb565_t                  pixel_out,
    output logic                     pix_out_valid,
    output logic [NUM_SPR-1:0]       coll_mask
);

    localparam int DEPTH = tex_depth(SPR_W, SPR_H, NUM_FRM);
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = (NUM_FRM > 1) ? $clog2(NUM_FRM) : 1;
    localparam int CW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int TXW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int YW    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic signed [POS_W:0] SPR_W_S = SPR_W[POS_W:0];
    localparam logic signed [POS_W:0] SPR_H_S = SPR_H[POS_W:0];

    logic [NUM_SPR-1:0] hit_vec;
    logic [NUM_SPR-1:0] hit_p1;
    rgb565_t            tex_p1 [NUM_SPR];
    rgb565_t            bg_p1;
    logic               vld_p1;

`ifndef SPR_MIRROR_EN
    logic unused_flip;
    assign unused_flip = ^spr_flip;
`endif

    for (genvar k = 0; k < NUM_SPR; k++) begin : g_ch
        logic signed [POS_W:0] dx;
        logic signed [POS_W:0] dy;
        logic [TXW-1:0]        tx;
        logic [FW-1:0]         frm_idx;
        logic [CW-1:0]         pulse_cnt;
        logic                  hit;
        logic                  wr_en;
        logic [AW-1:0]         rd_addr;

        // One extra borrow bit so a sprite parked near 4095 never aliases onto the left edge.
        assign dx  = $signed({2'b00, pixel_x}) - $signed({1'b0, spr_x[k*POS_W +: POS_W]});
        assign dy  = $signed({2'b00, pixel_y}) - $signed({1'b0, spr_y[k*POS_W +: POS_W]});
        assign hit = spr_en[k] && !dx[POS_W] && (dx < SPR_W_S)
                               && !dy[POS_W] && (dy < SPR_H_S);
        assign hit_vec[k] = hit;

`ifdef SPR_MIRROR_EN
        assign tx = spr_flip[k] ? (TXW'(SPR_W - 1) - dx[TXW-1:0]) : dx[TXW-1:0];
`else
        assign tx = dx[TXW-1:0];
`endif

        assign rd_addr = hit ? (AW'(frm_idx) * AW'(SPR_W * SPR_H)
                                + AW'(dy[YW-1:0]) * AW'(SPR_W) + AW'(tx))
                             : '0;

        assign wr_en = load_en && (load_sel == 3'(k)) && (32'(load_addr) < 32'(DEPTH));

        // Frame index only moves on frame_en, so a frame is always drawn from one texture frame.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                frm_idx   <= '0;
                pulse_cnt <= '0;
            end else if (frame_en && spr_anim[k]) begin
                if (pulse_cnt == CW'(ANIM_DIV - 1)) begin
                    pulse_cnt <= '0;
                    frm_idx   <= (frm_idx == FW'(NUM_FRM - 1)) ? '0 : frm_idx + FW'(1);
                end else begin
                    pulse_cnt <= pulse_cnt + CW'(1);
                end
            end
        end

        spr_tex_ram #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_en),
            .wr_addr (load_addr[AW-1:0]),
            .wr_data (load_data),
            .rd_addr (rd_addr),
            .rd_data (tex_p1[k])
        );
    end

    // Stage 1: hit flags and background alongside the RAM read
    always_ff @(posedge clk) begin
        hit_p1 <= hit_vec;
        bg_p1  <= bg_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pix_valid;
        end
    end

    logic [NUM_SPR-1:0] opaque;
    logic [NUM_SPR-1:0] coll_new;
    logic [NUM_SPR-1:0] coll_acc;
    rgb565_t            comp;

    always_comb begin
        opaque = '0;
        comp   = bg_p1;
        for (int k = NUM_SPR - 1; k >= 0; k--) begin
            opaque[k] = hit_p1[k] && (tex_p1[k] != KEY_COLOR);
            if (opaque[k]) begin
                comp = tex_p1[k];
            end
        end
    end

    assign coll_new = (vld_p1 && ((opaque & (opaque - NUM_SPR'(1))) != '0)) ? opaque : '0;

    // Stage 2: composite, output register and collision bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out     <= '0;
            pix_out_valid <= 1'b0;
            coll_mask     <= '0;
            coll_acc      <= '0;
        end else begin
            pixel_out     <= comp;
            pix_out_valid <= vld_p1;
            if (frame_en) begin
                coll_mask <= coll_acc;
                coll_acc  <= coll_new;
            end else begin
                coll_acc  <= coll_acc | coll_new;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: latency, keying, priority, collisions, animation, reset.
module tb_sprite_compositor;

    localparam int NS  = 4;
    localparam int W   = 64;
    localparam int H   = 48;
    localparam int FSZ = W * H;
    localparam logic [15:0] KEY = 16'h07E0;
    localparam logic [15:0] BG  = 16'h001F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [10:0]       pixel_x = '0;
    logic [10:0]       pixel_y = '0;
    logic              pix_valid = 1'b0;
    logic [15:0]       bg_data = '0;
    logic [NS*12-1:0]  spr_x = '0;
    logic [NS*12-1:0]  spr_y = '0;
    logic [NS-1:0]     spr_en = '0;
    logic [NS-1:0]     spr_anim = '0;
    logic [NS-1:0]     spr_flip = '0;
    logic              frame_en = 1'b0;
    logic              load_en = 1'b0;
    logic [2:0]        load_sel = '0;
    logic [15:0]       load_addr = '0;
    logic [15:0]       load_data = '0;
    logic [15:0]       pixel_out;
    logic              pix_out_valid;
    logic [NS-1:0]     coll_mask;

    sprite_compositor #(
        .NUM_SPR   (NS),
        .SPR_W     (W),
        .SPR_H     (H),
        .NUM_FRM   (4),
        .KEY_COLOR (KEY),
        .ANIM_DIV  (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .pix_valid     (pix_valid),
        .bg_data       (bg_data),
        .spr_x         (spr_x),
        .spr_y         (spr_y),
        .spr_en        (spr_en),
        .spr_anim      (spr_anim),
        .spr_flip      (spr_flip),
        .frame_en      (frame_en),
        .load_en       (load_en),
        .load_sel      (load_sel),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .pixel_out     (pixel_out),
        .pix_out_valid (pix_out_valid),
        .coll_mask     (coll_mask)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic        prev_chk = 1'b0;
    logic        prev_vld = 1'b0;
    logic [15:0] prev_pix = '0;
    string       prev_tag = "none";
    logic [15:0] cur_pix  = '0;
    string       cur_tag  = "none";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Advance one clock; the output now belongs to the inputs driven one tick earlier.
    task automatic tick();
        @(posedge clk);
        #1;
        if (prev_chk) begin
            check({prev_tag, " vld"}, 32'(pix_out_valid), 32'(prev_vld));
            if (prev_vld) check(prev_tag, 32'(pixel_out), 32'(prev_pix));
        end
        prev_chk = 1'b1;
        prev_vld = pix_valid;
        prev_pix = cur_pix;
        prev_tag = cur_tag;
    endtask

    task automatic px(input int x, input int y, input logic [15:0] bg,
                      input logic [15:0] exp, input string tag);
        pixel_x   = 11'(x);
        pixel_y   = 11'(y);
        bg_data   = bg;
        pix_valid = 1'b1;
        cur_pix   = exp;
        cur_tag   = tag;
        tick();
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic probe(input int x, input int y, input logic [15:0] exp, input string tag);
        px(x, y, BG, exp, tag);
        idle(1);
    endtask

    task automatic fpulse(input int n);
        pix_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            frame_en = 1'b1;
            tick();
            frame_en = 1'b0;
        end
    endtask

    task automatic load(input int sel, input int addr, input logic [15:0] d);
        pix_valid = 1'b0;
        load_en   = 1'b1;
        load_sel  = 3'(sel);
        load_addr = 16'(addr);
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_row(input int sel, input int frm, input int ty, input logic [15:0] d);
        for (int i = 0; i < W; i++) load(sel, frm * FSZ + ty * W + i, d);
    endtask

    task automatic set_pos(input int k, input int x, input int y);
        spr_x[k*12 +: 12] = 12'(x);
        spr_y[k*12 +: 12] = 12'(y);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] e;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        check("reset pixel_out", 32'(pixel_out), 32'h0);
        check("reset valid", 32'(pix_out_valid), 32'h0);
        check("reset coll_mask", 32'(coll_mask), 32'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        prev_chk = 1'b1;
        prev_vld = 1'b0;
        prev_tag = "post reset";
        idle(2);

        // Single sprite sweep, plus writes that must be ignored
        set_pos(0, 100, 200);
        spr_en = 4'b0001;
        load_row(0, 0, 10, 16'hF800);
        load(0, 16384 + 645, 16'h1234);
        load(4, 645, 16'h4321);
        for (int x = 90; x <= 175; x++) begin
            e = (x >= 100 && x <= 163) ? 16'hF800 : BG;
            px(x, 210, BG, e, "sweep y210");
        end
        idle(1);
        probe(120, 199, BG, "above sprite");
        probe(120, 248, BG, "below sprite");

        // Overlap priority and collisions
        set_pos(0, 300, 300);
        set_pos(1, 290, 300);
        load_row(0, 0, 0, 16'hAAAA);
        load_row(1, 0, 0, 16'h5555);
        spr_en = 4'b0011;
        for (int x = 285; x <= 370; x++) begin
            e = (x >= 300 && x <= 363) ? 16'hAAAA : (x >= 290 && x <= 299) ? 16'h5555 : BG;
            px(x, 300, BG, e, "overlap sweep");
        end
        idle(2);
        check("coll before frame_en", 32'(coll_mask), 32'h0);
        fpulse(1);
        check("coll after overlap", 32'(coll_mask), 32'h3);
        fpulse(1);
        check("coll clean frame", 32'(coll_mask), 32'h0);
        px(310, 300, BG, 16'hAAAA, "overlap again");
        px(311, 300, BG, 16'hAAAA, "overlap again");
        idle(2);
        fpulse(1);
        check("coll second frame", 32'(coll_mask), 32'h3);

        // Reset mid-line: outputs clear at once, textures survive
        px(354, 300, BG, 16'hAAAA, "pre reset");
        px(355, 300, BG, 16'hAAAA, "pre reset");
        #3 rst_n = 1'b0;
        #1;
        check("midline rst pixel_out", 32'(pixel_out), 32'h0);
        check("midline rst valid", 32'(pix_out_valid), 32'h0);
        check("midline rst coll_mask", 32'(coll_mask), 32'h0);
        prev_chk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("in reset valid", 32'(pix_out_valid), 32'h0);
        #3 rst_n = 1'b1;
        prev_chk = 1'b1;
        prev_vld = 1'b0;
        prev_tag = "release";
        for (int x = 356; x <= 360; x++) px(x, 300, BG, 16'hAAAA, "after reset");
        idle(2);
        fpulse(1);
        check("coll after reset", 32'(coll_mask), 32'h0);

        // Collision landing on the frame_en edge belongs to the next frame
        px(320, 300, BG, 16'hAAAA, "coincident px");
        fpulse(1);
        check("coll coincident", 32'(coll_mask), 32'h0);
        idle(1);
        fpulse(1);
        check("coll next frame", 32'(coll_mask), 32'h3);
        fpulse(1);
        check("coll cleared", 32'(coll_mask), 32'h0);

        // Transparent key over an opaque sprite, then over background
        set_pos(0, 500, 100);
        set_pos(1, 500, 100);
        load_row(0, 0, 0, KEY);
        load_row(1, 0, 0, 16'h1234);
        spr_en = 4'b0011;
        probe(510, 100, 16'h1234, "key over s1");
        probe(563, 100, 16'h1234, "key over s1 edge");
        probe(499, 100, BG, "left of sprites");
        fpulse(1);
        fpulse(1);
        check("key no collision", 32'(coll_mask), 32'h0);
        spr_en = 4'b0001;
        probe(510, 100, BG, "key over bg");

        // Animation on channel 2
        set_pos(2, 700, 50);
        for (int f = 0; f < 4; f++) load_row(2, f, 0, 16'(16'h1111 * (f + 1)));
        spr_en = 4'b0100;
        probe(710, 50, 16'h1111, "anim start");
        spr_anim = 4'b0100;
        fpulse(5);
        probe(710, 50, 16'h1111, "anim 5 pulses");
        fpulse(1);
        probe(710, 50, 16'h2222, "anim 6 pulses");
        fpulse(17);
        probe(710, 50, 16'h4444, "anim 23 pulses");
        fpulse(1);
        probe(710, 50, 16'h1111, "anim wrap 24");
        fpulse(6);
        probe(710, 50, 16'h2222, "anim 30 pulses");
        spr_anim = 4'b0000;
        fpulse(12);
        probe(710, 50, 16'h2222, "anim held");

        // Position near 4095 must not wrap onto the left edge
        set_pos(3, 4090, 50);
        spr_en = 4'b1000;
        load_row(3, 0, 0, 16'h7777);
        for (int x = 0; x <= 5; x++) px(x, 50, BG, BG, "wrap miss");
        idle(1);
        set_pos(3, 0, 50);
        probe(3, 50, 16'h7777, "wrap control");

        // Horizontal mirror
        set_pos(3, 800, 400);
        load_row(3, 0, 0, KEY);
        load(3, 0, 16'hBEEF);
        spr_flip = 4'b1000;
`ifdef SPR_MIRROR_EN
        probe(800, 400, BG, "mirror dx0");
        probe(863, 400, 16'hBEEF, "mirror dx63");
`else
        probe(800, 400, 16'hBEEF, "noflip dx0");
        probe(863, 400, BG, "noflip dx63");
`endif
        probe(801, 400, BG, "mirror dx1");

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
